// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory test engine.
package mem_test_pkg;
  localparam int unsigned DRAIN_CYCLES = 16;
  localparam int unsigned CNT_W        = 16;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_XOR   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mem_test_patt.sv
// Test pattern generator: pure function of word index and pattern mode.
module mem_test_patt
  import mem_test_pkg::*;
#(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         IDX_W    = 3,
  parameter logic [DATA_W-1:0]   TST_PATT = DATA_W'(32'h00FFFFFF)
) (
  input  mode_t             i_mode,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_patt
);

  logic [DATA_W-1:0] w_idx_ext;
  logic [DATA_W-1:0] w_walk;

  always_comb begin
    w_idx_ext = DATA_W'(i_idx);
    w_walk    = {{(DATA_W-1){1'b0}}, 1'b1} << (32'(i_idx) % DATA_W);
    o_patt    = TST_PATT;
    case (i_mode)
      MODE_CONST: o_patt = TST_PATT;
      MODE_INCR:  o_patt = w_idx_ext;
      MODE_WALK1: o_patt = w_walk;
      MODE_XOR:   o_patt = w_idx_ext ^ TST_PATT;
      default:    o_patt = TST_PATT;
    endcase
  end

endmodule

// File: rtl/mem_test_ctrl.sv
// Self-checking memory test engine: writes NUM_WORDS pattern words, reads
// them back, checks every returned beat in order and reports the outcome.
module mem_test_ctrl
  import mem_test_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 24,
  parameter int unsigned       CMP_W     = 24,
  parameter int unsigned       NUM_WORDS = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] TST_PATT  = DATA_W'(32'h00FFFFFF),
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              wr_rdy,
  input  logic              rd_rdy,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int unsigned       IDX_W    = $clog2(NUM_WORDS + 1);
  localparam int unsigned       WAIT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
  localparam int unsigned       WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0]  NUM_IDX  = IDX_W'(NUM_WORDS);
  // Masking instead of slicing keeps the unused high data bits referenced.
  localparam logic [DATA_W-1:0] CMP_MASK = ~({DATA_W{1'b1}} << CMP_W);

  state_t             r_state;
  state_t             w_state_nxt;
  mode_t              r_mode;
  logic [IDX_W-1:0]   r_wi;
  logic [IDX_W-1:0]   r_ri;
  logic [IDX_W-1:0]   r_ci;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_fail;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [ADDR_W-1:0]  r_first_err_addr;

  logic               w_start_ok;
  logic               w_chk_beat;
  logic               w_mismatch;
  logic               w_last_beat;
  logic               w_timeout;
  logic               w_drain_end;
  logic               w_overrun;
  logic               w_count_beat;
  logic [DATA_W-1:0]  w_wr_patt;
  logic [DATA_W-1:0]  w_chk_patt;

  mem_test_patt #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .TST_PATT (TST_PATT)
  ) u_wr_patt (
    .i_mode (r_mode),
    .i_idx  (r_wi),
    .o_patt (w_wr_patt)
  );

  mem_test_patt #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .TST_PATT (TST_PATT)
  ) u_chk_patt (
    .i_mode (r_mode),
    .i_idx  (r_ci),
    .o_patt (w_chk_patt)
  );

  always_comb begin
    w_start_ok   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    w_chk_beat   = rd_data_valid && (r_state == ST_READ);
    w_mismatch   = w_chk_beat && (((rd_data ^ w_chk_patt) & CMP_MASK) != '0);
    w_last_beat  = w_chk_beat && (r_ci == LAST_IDX);
    w_timeout    = (r_state == ST_READ) && !rd_data_valid && (r_wait == WAIT_W'(TIMEOUT - 1));
    w_drain_end  = (r_state == ST_DRAIN) && (r_wait == WAIT_W'(DRAIN_CYCLES - 1));
    w_overrun    = rd_data_valid && (r_state inside {ST_WRITE, ST_DRAIN, ST_DONE});
    w_count_beat = rd_data_valid && (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_WRITE;
      ST_WRITE:         if (wr_en && r_wi == LAST_IDX) w_state_nxt = ST_READ;
      ST_READ: begin
        if (w_last_beat)    w_state_nxt = ST_DRAIN;
        else if (w_timeout) w_state_nxt = ST_DONE;
      end
      ST_DRAIN:         if (w_drain_end) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en          = (r_state == ST_WRITE) && wr_rdy;
    wr_addr        = (r_state == ST_WRITE) ? BASE_ADDR + ADDR_W'(r_wi) : '0;
    wr_data        = (r_state == ST_WRITE) ? w_wr_patt : '0;
    rd_en          = (r_state == ST_READ) && rd_rdy && (r_ri < NUM_IDX);
    rd_addr        = (r_state == ST_READ) ? BASE_ADDR + ADDR_W'(r_ri) : '0;
    busy           = r_state inside {ST_WRITE, ST_READ, ST_DRAIN};
    done           = (r_state == ST_DONE);
    pass           = (r_state == ST_DONE) && !r_fail;
    fail           = r_fail;
    err_cnt        = r_err_cnt;
    rd_cnt         = r_rd_cnt;
    first_err_addr = r_first_err_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode           <= MODE_CONST;
      r_wi             <= '0;
      r_ri             <= '0;
      r_ci             <= '0;
      r_wait           <= '0;
      r_fail           <= 1'b0;
      r_err_cnt        <= '0;
      r_rd_cnt         <= '0;
      r_first_err_addr <= '0;
    end else begin
      // One counter serves both the read timeout and the drain window.
      if (w_state_nxt != r_state || (r_state == ST_READ && rd_data_valid))
        r_wait <= '0;
      else if (r_state inside {ST_READ, ST_DRAIN})
        r_wait <= r_wait + WAIT_W'(1);

      if (w_start_ok) begin
        r_mode    <= mode_t'(mode);
        r_wi      <= '0;
        r_ri      <= '0;
        r_ci      <= '0;
        r_fail    <= 1'b0;
        r_err_cnt <= '0;
        r_rd_cnt  <= '0;
      end else begin
        if (wr_en)      r_wi <= r_wi + IDX_W'(1);
        if (rd_en)      r_ri <= r_ri + IDX_W'(1);
        if (w_chk_beat) r_ci <= r_ci + IDX_W'(1);
        if (w_count_beat && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        if (w_mismatch) begin
          r_fail <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
          if (r_err_cnt == '0) r_first_err_addr <= BASE_ADDR + ADDR_W'(r_ci);
        end
        if (w_overrun || w_timeout) r_fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Bench for mem_test_ctrl: echoing memory model with fault injection plus a
// per-cycle checker against a behavioural pattern/result model.
module tb_mem_test_ctrl;
  localparam int NW = 6;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic        wr_rdy;
  logic        rd_rdy;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic [15:0] err_cnt;
  logic [23:0] first_err_addr;
  logic [15:0] rd_cnt;

  mem_test_ctrl #(.TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .wr_rdy         (wr_rdy),
    .rd_rdy         (rd_rdy),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .rd_cnt         (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          idx;
    logic [23:0] addr;
  } req_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] mem [0:15];
  req_t        rq [$];
  int          wcount, rcount, beats, exp_err, exp_rdcnt;
  logic [31:0] wdat [0:7];
  logic [1:0]  run_mode;
  int          corrupt_addr = -1;
  logic [31:0] corrupt_mask = '0;
  bit          rand_rdy = 0;
  bit          extra_beat = 0;
  bit          drop_last = 0;
  int          last_beat_cyc = 0;
  int          done_cyc = -1;
  bit          prev_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] patt(input logic [1:0] m, input int i);
    case (m)
      2'd0:    return 32'h00FFFFFF;
      2'd1:    return 32'(i);
      2'd2:    return 32'd1 << (i % 32);
      default: return 32'(i) ^ 32'h00FFFFFF;
    endcase
  endfunction

  // Memory model and per-cycle compare process.
  initial begin : model_loop
    logic [31:0] d;
    logic [31:0] p;
    req_t        r;
    wr_rdy = 1'b0; rd_rdy = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      wr_rdy = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      rd_rdy = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      rd_data_valid = 1'b0;
      rd_data = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        if (!(drop_last && r.idx == NW - 1)) begin
          d = mem[r.addr[3:0]];
          if (int'(r.addr) == corrupt_addr) d = d ^ corrupt_mask;
          rd_data_valid = 1'b1;
          rd_data = d;
          p = patt(run_mode, beats);
          if (beats < NW && d[23:0] != p[23:0]) exp_err++;
          beats++;
          exp_rdcnt++;
          last_beat_cyc = cyc;
        end
        if (extra_beat && r.idx == NW - 1) begin
          r.due = cyc + 1;
          r.idx = NW;
          rq.push_back(r);
        end
      end
      #1;
      chk("strobe_excl", 32'(wr_en & rd_en), 32'd0);
      if (wr_en) begin
        chk("wr_rdy_gate", 32'(wr_rdy), 32'd1);
        chk("wr_addr", 32'(wr_addr), 32'(wcount));
        chk("wr_data", wr_data, patt(run_mode, wcount));
        mem[wr_addr[3:0]] = wr_data;
        if (wcount < 8) wdat[wcount] = wr_data;
        wcount++;
      end
      if (rd_en) begin
        chk("rd_rdy_gate", 32'(rd_rdy), 32'd1);
        chk("rd_addr", 32'(rd_addr), 32'(rcount));
        r.due  = cyc + 3;
        r.idx  = rcount;
        r.addr = rd_addr;
        rq.push_back(r);
        rcount++;
      end
      @(posedge clk);
      #1;
      if (reset) begin
        chk("err_cnt_track", 32'(err_cnt), 32'(exp_err));
        chk("rd_cnt_track", 32'(rd_cnt), 32'(exp_rdcnt));
      end
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
    end
  end

  task automatic start_run(input logic [1:0] m);
    @(negedge clk);
    rq.delete();
    wcount = 0; rcount = 0; beats = 0; exp_err = 0; exp_rdcnt = 0;
    run_mode = m; done_cyc = -1;
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #2;
      if (done) break;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_flags"}, {28'd0, busy, done, pass, fail}, 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd0);
    chk({tag, "_first_err"}, 32'(first_err_addr), 32'd0);
  endtask

  logic [31:0] walk_exp [0:5];

  initial begin : main
    walk_exp = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20};
    reset = 1'b0; start = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset = 1'b1;

    // Constant pattern, always-ready memory
    start_run(2'd0);
    wait_done("t1");
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd6);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_fail", 32'(fail), 32'd0);
    chk("t1_writes", 32'(wcount), 32'd6);
    chk("t1_wdat5", wdat[5], 32'h00FFFFFF);

    // Incrementing pattern with bit 0 of address 3 corrupted
    corrupt_addr = 3; corrupt_mask = 32'h1;
    start_run(2'd1);
    wait_done("t2");
    chk("t2_fail", 32'(fail), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_first_err", 32'(first_err_addr), 32'd3);
    chk("t2_pass", 32'(pass), 32'd0);
    corrupt_addr = -1;

    // Walking one with random ready; mode input changes and start re-pulsed mid-run
    rand_rdy = 1;
    start_run(2'd2);
    mode = 2'd0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #2;
      if (rcount >= 2) break;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("t3");
    rand_rdy = 0;
    chk("t3_pass", 32'(pass), 32'd1);
    chk("t3_rd_cnt", 32'(rd_cnt), 32'd6);
    for (int i = 0; i < 6; i++) chk("t3_walk", wdat[i], walk_exp[i]);

    // Seven beats returned for six reads
    extra_beat = 1;
    start_run(2'd1);
    wait_done("t4");
    extra_beat = 0;
    chk("t4_fail", 32'(fail), 32'd1);
    chk("t4_rd_cnt", 32'(rd_cnt), 32'd7);
    chk("t4_err_cnt", 32'(err_cnt), 32'd0);
    chk("t4_pass", 32'(pass), 32'd0);

    // Last beat dropped: timeout
    drop_last = 1;
    start_run(2'd0);
    wait_done("t5");
    drop_last = 0;
    chk("t5_fail", 32'(fail), 32'd1);
    chk("t5_rd_cnt", 32'(rd_cnt), 32'd5);
    chk("t5_timeout_lat", 32'(done_cyc - last_beat_cyc), 32'd64);

    // Reset mid-write, then a clean run
    start_run(2'd0);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #2;
      if (wcount >= 2) break;
    end
    reset = 1'b0;
    #1 check_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_run(2'd0);
    wait_done("t6");
    chk("t6_pass", 32'(pass), 32'd1);
    chk("t6_writes", 32'(wcount), 32'd6);
    chk("t6_rd_cnt", 32'(rd_cnt), 32'd6);

    // XOR pattern; corruption above the compared bits is ignored
    corrupt_addr = 4; corrupt_mask = 32'h8000_0000;
    start_run(2'd3);
    wait_done("t7");
    corrupt_addr = -1;
    chk("t7_pass", 32'(pass), 32'd1);
    chk("t7_err_cnt", 32'(err_cnt), 32'd0);
    chk("t7_wdat2", wdat[2], 32'h00FFFFFD);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
